// File: rtl/wb_stream_writer_fifo.sv
// wb_stream_writer_fifo
// Buffers words pushed by the writer's Wishbone read-burst master and drains
// them onto a valid/ready stream. Storage is a dual-pointer RAM with a
// registered synchronous read port that feeds a single output register.
// A word read from the RAM first sits in the RAM read register ("in flight")
// and lands in the output register on the following edge. A new read may be
// issued whenever the output slot is free or is being emptied this cycle.
// Optional feature: define WB_STREAM_WRITER_FIFO_LAST_EN to build the packet
// word counter that drives stream_m_last_o from pkt_len.
module wb_stream_writer_fifo #(
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 4,
  parameter int PKT_W   = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [WB_DW-1:0]   fifo_d,
  input  logic               fifo_wr,
  output logic [FIFO_AW-1:0] fifo_cnt,
  output logic               fifo_full,
  output logic               overflow,
  output logic [WB_DW-1:0]   stream_m_data_o,
  output logic               stream_m_valid_o,
  input  logic               stream_m_ready_i,
  output logic               stream_m_last_o,
  input  logic [PKT_W-1:0]   pkt_len
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   OCC_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   OCC_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic [WB_DW-1:0]   mem [DEPTH];
  logic [WB_DW-1:0]   ram_rdata_q;

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   occ_q, occ_d;
  logic               inflight_q, inflight_d;
  logic               valid_q, valid_d;
  logic [WB_DW-1:0]   data_q, data_d;
  logic               overflow_q, overflow_d;

  logic full;
  logic transfer;
  logic rd_issue;
  logic land;
  logic wr_accept;

  // Per-cycle handshake decisions: a read needs a stored word and an output
  // slot that is empty or draining; an in-flight word lands under the same
  // slot condition, so the read register is always free when a read issues.
  always_comb begin
    full      = (occ_q == OCC_FULL);
    transfer  = valid_q & stream_m_ready_i;
    rd_issue  = (occ_q != '0) & (~valid_q | stream_m_ready_i);
    land      = inflight_q & (~valid_q | stream_m_ready_i);
    wr_accept = fifo_wr & (~full | rd_issue);
  end

  // Next-state computation for pointers, occupancy, output stage and overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    valid_d    = valid_q;
    data_d     = data_q;
    inflight_d = rd_issue | (inflight_q & ~land);
    overflow_d = overflow_q | (fifo_wr & ~wr_accept);

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (wr_accept && !rd_issue) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!wr_accept && rd_issue) begin
      occ_d = occ_q - OCC_ONE;
    end

    if (land) begin
      valid_d = 1'b1;
      data_d  = ram_rdata_q;
    end else if (transfer) begin
      valid_d = 1'b0;
    end
  end

  // RAM array and its registered read port; contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (wr_accept && !wb_rst_i) begin
      mem[wr_ptr_q] <= fifo_d;
    end
    if (rd_issue && !wb_rst_i) begin
      ram_rdata_q <= mem[rd_ptr_q];
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign fifo_cnt         = occ_q[FIFO_AW] ? '1 : occ_q[FIFO_AW-1:0];
  assign fifo_full        = full;
  assign overflow         = overflow_q;
  assign stream_m_data_o  = data_q;
  assign stream_m_valid_o = valid_q;

`ifdef WB_STREAM_WRITER_FIFO_LAST_EN
  localparam logic [PKT_W-1:0] PKT_ONE = PKT_W'(1);

  logic [PKT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [PKT_W-1:0] len_q, len_d;
  logic [PKT_W-1:0] len_eff;
  logic             is_last;

  // Packet word counter; pkt_len is taken live on the first word of a packet
  // and held in len_q for the rest of it.
  always_comb begin
    len_eff   = (pkt_cnt_q == '0) ? pkt_len : len_q;
    is_last   = (len_eff <= PKT_ONE) || (pkt_cnt_q == (len_eff - PKT_ONE));
    pkt_cnt_d = pkt_cnt_q;
    len_d     = len_q;
    if (transfer) begin
      if (pkt_cnt_q == '0) begin
        len_d = pkt_len;
      end
      pkt_cnt_d = is_last ? '0 : (pkt_cnt_q + PKT_ONE);
    end
  end

  // Packet counter registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pkt_cnt_q <= '0;
      len_q     <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      len_q     <= len_d;
    end
  end

  assign stream_m_last_o = valid_q & is_last;
`else
  logic unused_pkt_len;
  assign unused_pkt_len  = ^pkt_len;
  assign stream_m_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stream_writer_fifo.sv
// Testbench for wb_stream_writer_fifo. Stimulus is driven 1 time unit after
// the rising edge; transfers are captured on the falling edge into got_q and
// compared against the queue of words the bench itself pushed.
module tb_wb_stream_writer_fifo;

  localparam int WB_DW   = 32;
  localparam int FIFO_AW = 4;
  localparam int PKT_W   = 16;
  localparam int DEPTH   = 2 ** FIFO_AW;

  logic               clk;
  logic               rst;
  logic [WB_DW-1:0]   d;
  logic               wr;
  logic [FIFO_AW-1:0] cnt;
  logic               full;
  logic               ovf;
  logic [WB_DW-1:0]   data;
  logic               valid;
  logic               ready;
  logic               last;
  logic [PKT_W-1:0]   pkt_len;

  int checks;
  int failures;

  logic [WB_DW-1:0] exp_q[$];
  logic [WB_DW-1:0] got_q[$];
  logic             got_last_q[$];

  wb_stream_writer_fifo #(
    .WB_DW  (WB_DW),
    .FIFO_AW(FIFO_AW),
    .PKT_W  (PKT_W)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .fifo_d          (d),
    .fifo_wr         (wr),
    .fifo_cnt        (cnt),
    .fifo_full       (full),
    .overflow        (ovf),
    .stream_m_data_o (data),
    .stream_m_valid_o(valid),
    .stream_m_ready_i(ready),
    .stream_m_last_o (last),
    .pkt_len         (pkt_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every completed transfer (valid and ready seen before the edge).
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      got_q.push_back(data);
      got_last_q.push_back(last);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got time limit, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    wr = 1'b0;
    ready = 1'b0;
    d = '0;
    cycle();
    cycle();
    rst = 1'b0;
    got_q.delete();
    got_last_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_got(input int n, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (got_q.size() >= n) break;
      cycle();
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr = 1'b1;
    d = 32'hDEADBEEF;
    ready = 1'b1;
    pkt_len = 16'd1;
    cycle();
    cycle();
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (data !== '0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", data); end
    checks++; if (cnt !== '0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt); end
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", ovf); end
    checks++; if (last !== 1'b0) begin failures++; $display("[TB] FAIL reset_last: got %b expected 0", last); end
    wr = 1'b0;
    rst = 1'b0;
    cycle();
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_valid: got %b expected 0", valid); end
  endtask

  task automatic test_latency();
    logic [WB_DW-1:0] w [3];
    w[0] = 32'hA0; w[1] = 32'hA1; w[2] = 32'hA2;
    apply_reset();
    ready = 1'b1;
    wr = 1'b1;
    d = w[0];
    cycle();
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL lat_edge1_valid: got %b expected 0", valid); end
    d = w[1];
    cycle();
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL lat_edge2_valid: got %b expected 0", valid); end
    d = w[2];
    cycle();
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid !== 1'b1 || data !== w[i]) begin
        failures++;
        $display("[TB] FAIL lat_word%0d: got valid=%b data=%h expected valid=1 data=%h", i, valid, data, w[i]);
      end
      cycle();
    end
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL lat_empty_valid: got %b expected 0", valid); end
    checks++; if (data !== w[2]) begin failures++; $display("[TB] FAIL lat_hold_data: got %h expected %h", data, w[2]); end
    checks++; if (cnt !== '0) begin failures++; $display("[TB] FAIL lat_cnt: got %0d expected 0", cnt); end
  endtask

  // With ready low, the output register and the in-flight read register each
  // hold one word, so the RAM reaches DEPTH words after DEPTH+2 writes.
  task automatic test_full_overflow();
    bit ok;
    logic [WB_DW-1:0] w;
    apply_reset();
    ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr = 1'b1;
      w = $urandom;
      d = w;
      exp_q.push_back(w);
      cycle();
    end
    wr = 1'b0;
    checks++; if (cnt !== 4'd15) begin failures++; $display("[TB] FAIL full_cnt15: got %0d expected 15", cnt); end
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL full_not_yet: got %b expected 0", full); end
    wr = 1'b1;
    w = $urandom;
    d = w;
    exp_q.push_back(w);
    cycle();
    wr = 1'b0;
    checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL full_flag: got %b expected 1", full); end
    checks++; if (cnt !== 4'd15) begin failures++; $display("[TB] FAIL full_cnt_sat: got %0d expected 15", cnt); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL full_no_ovf: got %b expected 0", ovf); end
    wr = 1'b1;
    ready = 1'b1;
    w = $urandom;
    d = w;
    exp_q.push_back(w);
    cycle();
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL full_simul_ovf: got %b expected 0", ovf); end
    checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL full_simul_full: got %b expected 1", full); end
    ready = 1'b0;
    d = $urandom;
    cycle();
    wr = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL full_ovf_set: got %b expected 1", ovf); end
    ready = 1'b1;
    wait_got(exp_q.size(), 100, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL full_drain_timeout: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    cycle(); cycle(); cycle();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL full_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL full_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL full_end_valid: got %b expected 0", valid); end
    checks++; if (cnt !== '0) begin failures++; $display("[TB] FAIL full_end_cnt: got %0d expected 0", cnt); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL full_ovf_sticky: got %b expected 1", ovf); end
  endtask

  // Continuous writes with ready high: a word written at edge k transfers at
  // edge k+3, so after 100 writes exactly 97 words have left.
  task automatic test_back_to_back();
    bit ok;
    logic [WB_DW-1:0] w;
    apply_reset();
    ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr = 1'b1;
      w = $urandom;
      d = w;
      exp_q.push_back(w);
      cycle();
      checks++;
      if (cnt > 4'd1) begin failures++; $display("[TB] FAIL b2b_cnt at %0d: got %0d expected <=1", i, cnt); end
      if (i >= 2) begin
        checks++;
        if (valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid at %0d: got %b expected 1", i, valid); end
      end
    end
    wr = 1'b0;
    checks++; if (got_q.size() != 97) begin failures++; $display("[TB] FAIL b2b_rate: got %0d words expected 97", got_q.size()); end
    wait_got(100, 20, ok);
    checks++; if (!ok || got_q.size() != 100) begin failures++; $display("[TB] FAIL b2b_total: got %0d expected 100", got_q.size()); end
    for (int i = 0; i < 100 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL b2b_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_ready_toggle();
    bit [3:0] pat;
    logic pv, pr;
    logic [WB_DW-1:0] pd, w;
    pat = 4'b1001;
    apply_reset();
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1;
      w = $urandom;
      d = w;
      exp_q.push_back(w);
      cycle();
    end
    wr = 1'b0;
    cycle(); cycle(); cycle();
    for (int i = 0; i < 80; i++) begin
      ready = pat[3 - (i % 4)];
      pv = valid; pd = data; pr = ready;
      cycle();
      if (pv && !pr) begin
        checks++;
        if (valid !== 1'b1 || data !== pd) begin
          failures++;
          $display("[TB] FAIL toggle_stable at %0d: got valid=%b data=%h expected valid=1 data=%h", i, valid, data, pd);
        end
      end
      if (got_q.size() >= 8) break;
    end
    ready = 1'b1;
    cycle(); cycle(); cycle();
    checks++; if (got_q.size() != 8) begin failures++; $display("[TB] FAIL toggle_count: got %0d expected 8", got_q.size()); end
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL toggle_end_valid: got %b expected 0", valid); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL toggle_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1;
      d = 32'h100 + i;
      cycle();
    end
    wr = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid1: got %b expected 0", valid); end
    checks++; if (cnt !== '0) begin failures++; $display("[TB] FAIL midrst_cnt: got %0d expected 0", cnt); end
    cycle();
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid2: got %b expected 0", valid); end
    rst = 1'b0;
    got_q.delete();
    got_last_q.delete();
    wr = 1'b1;
    d = 32'h55;
    cycle();
    wr = 1'b0;
    ready = 1'b1;
    repeat (8) cycle();
    checks++; if (got_q.size() != 1) begin failures++; $display("[TB] FAIL midrst_count: got %0d expected 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0] !== 32'h55) begin failures++; $display("[TB] FAIL midrst_word: got %h expected 00000055", got_q[0]); end
    end
  endtask

  // Random writes and ready; writes are held back only while the bench knows
  // DEPTH words are outstanding, so nothing can be dropped.
  task automatic test_random_traffic();
    bit ok;
    logic pv, pr;
    logic [WB_DW-1:0] pd, w;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      wr = ($urandom_range(0, 1) == 1) && ((exp_q.size() - got_q.size()) < DEPTH);
      if (wr) begin
        w = $urandom;
        d = w;
        exp_q.push_back(w);
      end
      ready = ($urandom_range(0, 3) != 0);
      pv = valid; pd = data; pr = ready;
      cycle();
      if (pv && !pr) begin
        checks++;
        if (valid !== 1'b1 || data !== pd) begin
          failures++;
          $display("[TB] FAIL rand_stable at %0d: got valid=%b data=%h expected valid=1 data=%h", i, valid, data, pd);
        end
      end
    end
    wr = 1'b0;
    ready = 1'b1;
    wait_got(exp_q.size(), 60, ok);
    cycle(); cycle();
    checks++; if (!ok || got_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL rand_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL rand_overflow: got %b expected 0", ovf); end
  endtask

  task automatic test_last();
    bit ok;
`ifdef WB_STREAM_WRITER_FIFO_LAST_EN
    int lens [3];
    int nwords [3];
    lens[0] = 4; lens[1] = 1; lens[2] = 0;
    nwords[0] = 10; nwords[1] = 6; nwords[2] = 3;
    for (int t = 0; t < 3; t++) begin
      apply_reset();
      pkt_len = PKT_W'(lens[t]);
      ready = 1'b1;
      for (int i = 0; i < nwords[t]; i++) begin
        wr = 1'b1;
        d = $urandom;
        cycle();
      end
      wr = 1'b0;
      wait_got(nwords[t], 20, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL last_timeout len=%0d: got %0d expected %0d", lens[t], got_q.size(), nwords[t]); end
      for (int i = 0; i < nwords[t] && i < got_last_q.size(); i++) begin
        checks++;
        if (got_last_q[i] !== ((lens[t] <= 1) || ((i % lens[t]) == lens[t] - 1))) begin
          failures++;
          $display("[TB] FAIL last len=%0d word%0d: got %b expected %b", lens[t], i, got_last_q[i], (lens[t] <= 1) || ((i % lens[t]) == lens[t] - 1));
        end
      end
    end
`else
    apply_reset();
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1;
      d = $urandom;
      pkt_len = PKT_W'($urandom_range(0, 3));
      cycle();
      checks++;
      if (last !== 1'b0) begin failures++; $display("[TB] FAIL last_off at %0d: got %b expected 0", i, last); end
    end
    wr = 1'b0;
    wait_got(10, 20, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL last_off_timeout: got %0d expected 10", got_q.size()); end
    for (int i = 0; i < got_last_q.size(); i++) begin
      checks++;
      if (got_last_q[i] !== 1'b0) begin failures++; $display("[TB] FAIL last_off_word%0d: got %b expected 0", i, got_last_q[i]); end
    end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    wr = 1'b0;
    ready = 1'b0;
    d = '0;
    pkt_len = '0;
    test_reset();
    test_latency();
    test_full_overflow();
    test_back_to_back();
    test_ready_toggle();
    test_reset_midstream();
    test_random_traffic();
    test_last();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
